pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk, input, 1, rising-edge clock; rst_n, input, 1, asynchronous active-low reset.
REQ-002 instr_id  input  16  instruction held in the IF/ID register.
REQ-003 reg_wrt_ex  input  1  instruction in ID/EX writes the register file.
REQ-004 mem_read_ex  input  1  instruction in ID/EX is a load.
REQ-005 target_reg_ex  input  3  destination register of the ID/EX instruction.
REQ-006 imem_stall  input  1  instruction memory busy; the fetch word is not yet valid.
REQ-007 dmem_stall  input  1  data memory busy with the EX/MEM access.
REQ-008 redirect  input  1  taken branch or jump resolved this cycle (PC changes).
REQ-009 halt_wb  input  1  HALT instruction in the MEM/WB stage.
REQ-010 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register write enables.
REQ-011 ifid_bubble, idex_bubble, memwb_bubble  output  1 each  load a NOP into that register instead of its input.
REQ-012 stall_cnt  output  16  saturating count of stalled cycles.
REQ-013 state  output  3  current FSM state, for debug.

Function
REQ-014 FSM states: RUN, LDUSE, DWAIT, IWAIT, HALTED; the state register is the only registered control.
REQ-015 Rs-used: opcode instr_id[15:11] is not in {00000, 00001, 00100, 00110, 11000}.
REQ-016 Rt-used: either (a) [15:14]=11 and opcode not in {11000, 11001}, or (b) opcode is 10000 or 10011.
REQ-017 load_use = mem_read_ex & reg_wrt_ex & ((Rs-used & instr_id[10:8]=target_reg_ex) | (Rt-used & instr_id[7:5]=target_reg_ex)).
REQ-018 Priority, highest first: dmem_stall > load_use > imem_stall > redirect > normal flow.
REQ-019 dmem_stall=1: pc/ifid/idex/exmem enables=0 and memwb_bubble=1; state goes to DWAIT; DWAIT returns to RUN in the first cycle dmem_stall=0, with all enables=1 in that cycle.
REQ-020 load_use=1 with no dmem_stall: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=memwb_en=1; state goes to LDUSE for exactly one cycle, then to RUN.
REQ-021 In LDUSE, load_use is re-evaluated; a second consecutive match (the load is now in EX/MEM) SHALL NOT stall again, because forwarding covers it.
REQ-022 imem_stall=1 with no higher-priority event: pc_en=0, ifid_bubble=1, downstream enables=1; state goes to IWAIT until imem_stall=0.
REQ-023 redirect=1 in RUN: ifid_bubble=1 for one cycle (flushes the wrong-path fetch); pc_en=1.
REQ-024 redirect=1 during IWAIT: the redirect SHALL set redirect_pending; pc_en=1 that cycle so the new PC is captured.
REQ-025 When the fetch completes with redirect_pending=1: that fetched word is discarded (ifid_bubble=1), redirect_pending clears, and no extra cycle is lost.
REQ-026 halt_wb=1: transition to HALTED; HALTED is terminal until reset; all enables=0 and bubbles=0.
REQ-027 stall_cnt increments on each clock with pc_en=0 and state!=HALTED; it saturates at 16'hFFFF with no wrap.
REQ-028 A dmem_stall arriving during LDUSE or IWAIT SHALL preempt to DWAIT; the frozen ID/EX bubble is kept, and the pending condition is re-evaluated on exit.

Reset
REQ-029 rst_n low SHALL asynchronously force: state=RUN, redirect_pending=0, stall_cnt=0.
REQ-030 While rst_n is low: all *_en=0 and all *_bubble=1.
REQ-031 The first rising edge after deassertion SHALL behave as RUN with no pending events.
REQ-032 Reset asserted mid-stall SHALL abandon the stall without residue.

Structure
REQ-033 A shared package pipe_ctrl_pkg SHALL hold the state encoding (RUN=0, LDUSE=1, DWAIT=2, IWAIT=3, HALTED=4) and the opcode constants used in REQ-015 and REQ-016.
REQ-034 Combinational detection per REQ-015 to REQ-017 SHALL be in the sub-module load_use_detect; the FSM, counter and enables stay in pipe_hazard_ctrl.

Verification
REQ-035 Scenario: instr_id=ADD r1,r2,r3 (16'hD264), mem_read_ex=1, reg_wrt_ex=1, target_reg_ex=2 -> exactly one cycle with pc_en=0, idex_bubble=1, state=LDUSE, then RUN; stall_cnt=1.
REQ-036 Scenario: same but instr_id=LBI r2 (opcode 11000) with target 2 -> no stall.
REQ-037 Scenario: imem_stall high 3 cycles, redirect pulsed in the 2nd -> pc_en=1 only in the redirect cycle; on completion ifid_bubble=1 once; stall_cnt=2.
REQ-038 Scenario: load_use and dmem_stall together for 2 cycles -> DWAIT with memwb_bubble=1 for 2 cycles, then LDUSE for 1 cycle, then RUN.
REQ-039 Scenario: halt_wb=1 -> HALTED; all enables stay 0 for 100 cycles; stall_cnt is unchanged.
REQ-040 Scenario: rst_n pulled low mid-DWAIT -> outputs take reset values immediately (before the next edge); after release, state=RUN and stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// field widths and the opcodes that decide which source registers an
// instruction actually reads.
package pipe_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 3'd0,
    ST_LDUSE  = 3'd1,
    ST_DWAIT  = 3'd2,
    ST_IWAIT  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Opcodes that read no Rs
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_J    = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_JAL  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_LBI  = 5'b11000;

  // 11xxx opcodes that do not read Rt
  localparam logic [OPC_W-1:0] OPC_BTR  = 5'b11001;

  // Stores outside the 11xxx group that read Rt as the store data
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_STU  = 5'b10011;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection.
//   instr_id      : instruction in IF/ID
//   reg_wrt_ex    : ID/EX instruction writes the register file
//   mem_read_ex   : ID/EX instruction is a load
//   target_reg_ex : ID/EX destination register
//   load_use_c    : ID instruction reads the register the EX load produces
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_id,
  input  logic               reg_wrt_ex,
  input  logic               mem_read_ex,
  input  logic [REG_W-1:0]   target_reg_ex,
  output logic               load_use_c
);

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             rs_used;
  logic             rt_used;
  logic             unused_bits;

  assign opc = instr_id[15:11];
  assign rs  = instr_id[10:8];
  assign rt  = instr_id[7:5];

  // Low field bits are immediates / Rd and never matter for the hazard
  assign unused_bits = ^instr_id[4:0];

  // Source-register usage decode
  always_comb begin
    rs_used = !((opc == OPC_HALT) || (opc == OPC_NOP) || (opc == OPC_J) ||
                (opc == OPC_JAL)  || (opc == OPC_LBI));
    rt_used = ((opc[4:3] == 2'b11) && (opc != OPC_LBI) && (opc != OPC_BTR)) ||
              (opc == OPC_ST) || (opc == OPC_STU);
  end

  assign load_use_c = mem_read_ex & reg_wrt_ex &
                      ((rs_used & (rs == target_reg_ex)) |
                       (rt_used & (rt == target_reg_ex)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates data-memory stalls, load-use
// interlocks, instruction-fetch stalls, redirects and HALT, and produces the
// pipeline register enables / bubble injects plus a saturating stall counter.
//   clk, rst_n            : clock, async active-low reset
//   instr_id ..           : hazard sources (see load_use_detect)
//   imem_stall/dmem_stall : memory busy indications
//   redirect              : taken branch/jump this cycle
//   halt_wb               : HALT reached MEM/WB
//   *_en / *_bubble       : pipeline register controls (decoded from state)
//   stall_cnt             : saturating count of cycles with pc_en low
//   state                 : current FSM state
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   instr_id,
  input  logic                 reg_wrt_ex,
  input  logic                 mem_read_ex,
  input  logic [REG_W-1:0]     target_reg_ex,
  input  logic                 imem_stall,
  input  logic                 dmem_stall,
  input  logic                 redirect,
  input  logic                 halt_wb,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_bubble,
  output logic                 idex_bubble,
  output logic                 memwb_bubble,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [STATE_W-1:0]   state
);

  state_e           state_q, state_d;
  logic             redirect_pending_q, redirect_pending_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use_raw;
  logic load_use_eff;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_bubble_c, idex_bubble_c, memwb_bubble_c;

  load_use_detect u_lud (
    .instr_id      (instr_id),
    .reg_wrt_ex    (reg_wrt_ex),
    .mem_read_ex   (mem_read_ex),
    .target_reg_ex (target_reg_ex),
    .load_use_c    (load_use_raw)
  );

  // After one interlock cycle the load sits in EX/MEM and forwarding covers it
  assign load_use_eff = load_use_raw & (state_q != ST_LDUSE);

  // Next-state and control decode, highest-priority hazard first
  always_comb begin
    state_d            = state_q;
    redirect_pending_d = redirect_pending_q;
    pc_en_c            = 1'b1;
    ifid_en_c          = 1'b1;
    idex_en_c          = 1'b1;
    exmem_en_c         = 1'b1;
    memwb_en_c         = 1'b1;
    ifid_bubble_c      = 1'b0;
    idex_bubble_c      = 1'b0;
    memwb_bubble_c     = 1'b0;

    if (state_q == ST_HALTED) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
    end else begin
      if (dmem_stall) begin
        // Freeze everything up to EX/MEM; keep pending state for the exit cycle
        pc_en_c        = 1'b0;
        ifid_en_c      = 1'b0;
        idex_en_c      = 1'b0;
        exmem_en_c     = 1'b0;
        memwb_bubble_c = 1'b1;
        state_d        = ST_DWAIT;
      end else if (load_use_eff) begin
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        idex_bubble_c = 1'b1;
        state_d       = ST_LDUSE;
      end else if (imem_stall) begin
        pc_en_c       = 1'b0;
        ifid_bubble_c = 1'b1;
        state_d       = ST_IWAIT;
        // Capture the new PC now; the outstanding fetch becomes wrong-path
        if (redirect) begin
          pc_en_c            = 1'b1;
          redirect_pending_d = 1'b1;
        end
      end else begin
        // Normal flow; drop a wrong-path word from a redirect now or earlier
        state_d            = ST_RUN;
        ifid_bubble_c      = redirect | redirect_pending_q;
        redirect_pending_d = 1'b0;
      end
      if (halt_wb) begin
        state_d = ST_HALTED;
      end
    end
  end

  // Saturating stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_c && (state_q != ST_HALTED) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, pending redirect and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_RUN;
      redirect_pending_q <= 1'b0;
      stall_cnt_q        <= '0;
    end else begin
      state_q            <= state_d;
      redirect_pending_q <= redirect_pending_d;
      stall_cnt_q        <= stall_cnt_d;
    end
  end

  // Reset holds the pipeline frozen with bubbles asserted
  assign pc_en        = rst_n & pc_en_c;
  assign ifid_en      = rst_n & ifid_en_c;
  assign idex_en      = rst_n & idex_en_c;
  assign exmem_en     = rst_n & exmem_en_c;
  assign memwb_en     = rst_n & memwb_en_c;
  assign ifid_bubble  = ~rst_n | ifid_bubble_c;
  assign idex_bubble  = ~rst_n | idex_bubble_c;
  assign memwb_bubble = ~rst_n | memwb_bubble_c;
  assign stall_cnt    = stall_cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each stimulus cycle pushes its
// hand-computed expected controls, state and stall count; a monitor pops and
// compares them mid-cycle.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_id = 16'h0800;
  logic        reg_wrt_ex = 1'b0;
  logic        mem_read_ex = 1'b0;
  logic [2:0]  target_reg_ex = 3'd0;
  logic        imem_stall = 1'b0;
  logic        dmem_stall = 1'b0;
  logic        redirect = 1'b0;
  logic        halt_wb = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_bubble, idex_bubble, memwb_bubble;
  logic [15:0] stall_cnt;
  logic [2:0]  state;

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_id      (instr_id),
    .reg_wrt_ex    (reg_wrt_ex),
    .mem_read_ex   (mem_read_ex),
    .target_reg_ex (target_reg_ex),
    .imem_stall    (imem_stall),
    .dmem_stall    (dmem_stall),
    .redirect      (redirect),
    .halt_wb       (halt_wb),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .ifid_bubble   (ifid_bubble),
    .idex_bubble   (idex_bubble),
    .memwb_bubble  (memwb_bubble),
    .stall_cnt     (stall_cnt),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Control vector: {pc, ifid, idex, exmem, memwb, ifid_b, idex_b, memwb_b}
  localparam logic [7:0] C_NORM = 8'hF8;
  localparam logic [7:0] C_LU   = 8'h3A;
  localparam logic [7:0] C_DW   = 8'h09;
  localparam logic [7:0] C_IW   = 8'h7C;
  localparam logic [7:0] C_FLSH = 8'hFC;
  localparam logic [7:0] C_HALT = 8'h00;
  localparam logic [7:0] C_RST  = 8'h07;

  localparam logic [2:0] S_RUN = 3'd0, S_LDUSE = 3'd1, S_DWAIT = 3'd2,
                         S_IWAIT = 3'd3, S_HALTED = 3'd4;

  localparam logic [15:0] I_ADD  = 16'hD264; // ADD r1,r2,r3: rs=2 rt=3
  localparam logic [15:0] I_LBI  = 16'hC200; // LBI r2: no Rs/Rt read
  localparam logic [15:0] I_ST   = 16'h8180; // ST: rs=1 rt=4
  localparam logic [15:0] I_BTR  = 16'hCD60; // BTR: rs=5, rt field 3 unused

  typedef struct packed {
    logic [7:0]  ctl;
    logic [2:0]  st;
    logic [15:0] cnt;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   vec_id = 0;
  logic [7:0] ctl_act;

  assign ctl_act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_bubble, idex_bubble, memwb_bubble};

  task automatic chk(input string name, input int id, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, id, act, exp);
  endtask

  // Drive one cycle of inputs and queue its expected response
  task automatic step(input logic r, input logic [15:0] ins, input logic rw,
                      input logic mr, input logic [2:0] tg, input logic im,
                      input logic dm, input logic rd, input logic hw,
                      input logic [7:0] ectl, input logic [2:0] est,
                      input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; instr_id = ins; reg_wrt_ex = rw; mem_read_ex = mr;
    target_reg_ex = tg; imem_stall = im; dmem_stall = dm; redirect = rd;
    halt_wb = hw;
    e.ctl = ectl; e.st = est; e.cnt = ecnt; e.id = 16'(vec_id);
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctl",       int'(e.id), int'(ctl_act),   int'(e.ctl));
        chk("state",     int'(e.id), int'(state),     int'(e.st));
        chk("stall_cnt", int'(e.id), int'(stall_cnt), int'(e.cnt));
      end
    end
  end

  initial begin
    // Reset values while rst_n is low
    step(0, I_ADD, 0, 0, 3'd0, 0, 0, 0, 0, C_RST,  S_RUN, 16'd0);
    step(0, I_ADD, 1, 1, 3'd2, 1, 1, 1, 0, C_RST,  S_RUN, 16'd0);
    step(1, I_ADD, 0, 0, 3'd2, 0, 0, 0, 0, C_NORM, S_RUN, 16'd0);
    // Load-use on Rs: one interlock cycle, second match ignored
    step(1, I_ADD, 1, 1, 3'd2, 0, 0, 0, 0, C_LU,   S_RUN,   16'd0);
    step(1, I_ADD, 1, 1, 3'd2, 0, 0, 0, 0, C_NORM, S_LDUSE, 16'd1);
    step(1, I_ADD, 0, 0, 3'd2, 0, 0, 0, 0, C_NORM, S_RUN,   16'd1);
    // Load-use on Rt
    step(1, I_ADD, 1, 1, 3'd3, 0, 0, 0, 0, C_LU,   S_RUN,   16'd1);
    step(1, I_ADD, 0, 0, 3'd3, 0, 0, 0, 0, C_NORM, S_LDUSE, 16'd2);
    // Load that does not write, LBI (no sources), BTR (Rt not read)
    step(1, I_ADD, 0, 1, 3'd2, 0, 0, 0, 0, C_NORM, S_RUN, 16'd2);
    step(1, I_LBI, 1, 1, 3'd2, 0, 0, 0, 0, C_NORM, S_RUN, 16'd2);
    step(1, I_BTR, 1, 1, 3'd3, 0, 0, 0, 0, C_NORM, S_RUN, 16'd2);
    // Store reads Rt
    step(1, I_ST,  1, 1, 3'd4, 0, 0, 0, 0, C_LU,   S_RUN,   16'd2);
    step(1, I_ST,  0, 0, 3'd4, 0, 0, 0, 0, C_NORM, S_LDUSE, 16'd3);
    // Fetch stall with redirect in the 2nd cycle
    step(1, I_LBI, 0, 0, 3'd0, 1, 0, 0, 0, C_IW,   S_RUN,   16'd3);
    step(1, I_LBI, 0, 0, 3'd0, 1, 0, 1, 0, C_FLSH, S_IWAIT, 16'd4);
    step(1, I_LBI, 0, 0, 3'd0, 1, 0, 0, 0, C_IW,   S_IWAIT, 16'd4);
    step(1, I_LBI, 0, 0, 3'd0, 0, 0, 0, 0, C_FLSH, S_IWAIT, 16'd5);
    step(1, I_LBI, 0, 0, 3'd0, 0, 0, 0, 0, C_NORM, S_RUN,   16'd5);
    // Redirect in RUN flushes one fetch
    step(1, I_LBI, 0, 0, 3'd0, 0, 0, 1, 0, C_FLSH, S_RUN, 16'd5);
    step(1, I_LBI, 0, 0, 3'd0, 0, 0, 0, 0, C_NORM, S_RUN, 16'd5);
    // Load-use under data stall: DWAIT x2, then LDUSE once
    step(1, I_ADD, 1, 1, 3'd2, 0, 1, 0, 0, C_DW,   S_RUN,   16'd5);
    step(1, I_ADD, 1, 1, 3'd2, 0, 1, 0, 0, C_DW,   S_DWAIT, 16'd6);
    step(1, I_ADD, 1, 1, 3'd2, 0, 0, 0, 0, C_LU,   S_DWAIT, 16'd7);
    step(1, I_ADD, 1, 1, 3'd2, 0, 0, 0, 0, C_NORM, S_LDUSE, 16'd8);
    step(1, I_ADD, 0, 0, 3'd2, 0, 0, 0, 0, C_NORM, S_RUN,   16'd8);
    // Data stall preempting a fetch stall
    step(1, I_LBI, 0, 0, 3'd0, 1, 0, 0, 0, C_IW,   S_RUN,   16'd8);
    step(1, I_LBI, 0, 0, 3'd0, 1, 1, 0, 0, C_DW,   S_IWAIT, 16'd9);
    step(1, I_LBI, 0, 0, 3'd0, 0, 0, 0, 0, C_NORM, S_DWAIT, 16'd10);
    // Reset mid-DWAIT takes effect before the next edge
    step(1, I_LBI, 0, 0, 3'd0, 0, 1, 0, 0, C_DW,   S_RUN,   16'd10);
    step(1, I_LBI, 0, 0, 3'd0, 0, 1, 0, 0, C_DW,   S_DWAIT, 16'd11);
    step(0, I_LBI, 0, 0, 3'd0, 0, 1, 0, 0, C_RST,  S_RUN,   16'd0);
    step(1, I_LBI, 0, 0, 3'd0, 0, 0, 0, 0, C_NORM, S_RUN,   16'd0);
    // Counter saturation under a long fetch stall
    step(1, I_LBI, 0, 0, 3'd0, 1, 0, 0, 0, C_IW,   S_RUN,   16'd0);
    repeat (65540) @(posedge clk);
    step(1, I_LBI, 0, 0, 3'd0, 1, 0, 0, 0, C_IW,   S_IWAIT, 16'hFFFF);
    step(1, I_LBI, 0, 0, 3'd0, 0, 0, 0, 0, C_NORM, S_IWAIT, 16'hFFFF);
    step(0, I_LBI, 0, 0, 3'd0, 0, 0, 0, 0, C_RST,  S_RUN,   16'd0);
    // HALT is terminal and ignores every hazard
    step(1, I_LBI, 0, 0, 3'd0, 0, 0, 0, 1, C_NORM, S_RUN,   16'd0);
    for (int i = 0; i < 100; i++) begin
      step(1, I_ADD, 1, 1, 3'd2, 1, 1, 1, 0, C_HALT, S_HALTED, 16'd0);
    end
    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
